// File: rtl/vxe_vpu_pkg.sv
// Shared constants and types for the VPU register file slice.
package vxe_vpu_pkg;

  localparam int unsigned VXE_VPU_NTHREADS = 8;
  localparam int unsigned VXE_VPU_NREGS    = 8;
  localparam int unsigned VXE_VPU_RDW      = 38;
  localparam int unsigned VXE_VPU_THW      = 3;
  localparam int unsigned VXE_VPU_RIW      = 3;
  // Width of each thread's accumulator lane on o_acc
  localparam int unsigned VXE_VPU_ACCW     = 32;

  // Register index constants
  localparam logic [VXE_VPU_RIW-1:0] VXE_VPU_RIDX_ACC = 3'd0;

  // Writeback tracker state encoding
  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/vxe_vpu_rf_wbtrk.sv
// Writeback tracker: records which enabled threads still owe an ACC write
// after an arm pulse and reports completion.
module vxe_vpu_rf_wbtrk
  import vxe_vpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [VXE_VPU_NTHREADS-1:0] i_en,
  input  logic                        i_wb_arm,
  input  logic                        i_acc_wr,
  input  logic [VXE_VPU_THW-1:0]      i_acc_th,
  output logic                        o_wb_done
);

  wb_state_e                   state_q, state_d;
  logic [VXE_VPU_NTHREADS-1:0] pend_q, pend_d;
  logic [VXE_VPU_NTHREADS-1:0] clr_mask;

  // Next pending mask; a same-cycle ACC write is applied after (re)arming
  always_comb begin
    clr_mask = '0;
    if (i_acc_wr) clr_mask[i_acc_th] = 1'b1;
    pend_d = pend_q;
    if (i_wb_arm) begin
      pend_d = i_en & ~clr_mask;
    end else if (state_q == WB_WAIT) begin
      pend_d = pend_q & ~clr_mask;
    end
    state_d = (pend_d != '0) ? WB_WAIT : WB_IDLE;
  end

  // State and pending mask registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= WB_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign o_wb_done = (state_q == WB_IDLE);

endmodule

// File: rtl/vxe_vpu_rf.sv
// Per-thread VPU register file: 8 threads x 8 regs x 38 bits, writeback
// port, registered control read port, thread enables and completion tracker.
module vxe_vpu_rf
  import vxe_vpu_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     nrst,
  input  logic [VXE_VPU_THW-1:0]                   i_th,
  input  logic [VXE_VPU_RIW-1:0]                   i_ridx,
  input  logic                                     i_wr_en,
  input  logic [VXE_VPU_RDW-1:0]                   i_data,
  input  logic                                     i_en_we,
  input  logic [VXE_VPU_NTHREADS-1:0]              i_en_mask,
  input  logic                                     i_wb_arm,
  output logic                                     o_wb_done,
  output logic                                     o_wr_err,
  input  logic                                     i_err_clr,
  input  logic [VXE_VPU_THW-1:0]                   i_rd_th,
  input  logic [VXE_VPU_RIW-1:0]                   i_rd_ridx,
  input  logic                                     i_rd_en,
  output logic [VXE_VPU_RDW-1:0]                   o_rd_data,
  output logic                                     o_rd_vld,
  output logic [VXE_VPU_NTHREADS*VXE_VPU_ACCW-1:0] o_acc,
  output logic [VXE_VPU_NTHREADS-1:0]              o_en
);

  logic [VXE_VPU_RDW-1:0]      regs_q [VXE_VPU_NTHREADS][VXE_VPU_NREGS];
  logic [VXE_VPU_NTHREADS-1:0] en_q;
  logic                        wr_err_q, wr_err_d;
  logic [VXE_VPU_RDW-1:0]      rd_data_q, rd_data_d;
  logic                        rd_vld_q;
  logic                        acc_wr;

  assign acc_wr = i_wr_en && (i_ridx == VXE_VPU_RIDX_ACC);

  // Register storage; disabled threads are still written
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int t = 0; t < VXE_VPU_NTHREADS; t++) begin
        for (int r = 0; r < VXE_VPU_NREGS; r++) begin
          regs_q[t][r] <= '0;
        end
      end
    end else if (i_wr_en) begin
      regs_q[i_th][i_ridx] <= i_data;
    end
  end

  // Read mux with same-cycle write bypass; data holds when no request
  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_en) begin
      if (i_wr_en && (i_th == i_rd_th) && (i_ridx == i_rd_ridx)) begin
        rd_data_d = i_data;
      end else begin
        rd_data_d = regs_q[i_rd_th][i_rd_ridx];
      end
    end
  end

  // Sticky write error: a set beats a same-cycle clear
  always_comb begin
    wr_err_d = wr_err_q;
    if (i_wr_en && !en_q[i_th]) begin
      wr_err_d = 1'b1;
    end else if (i_err_clr) begin
      wr_err_d = 1'b0;
    end
  end

  // Enable mask, error flag and read port registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_q      <= '0;
      wr_err_q  <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      if (i_en_we) en_q <= i_en_mask;
      wr_err_q  <= wr_err_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= i_rd_en;
    end
  end

  // Accumulator lanes straight from storage
  for (genvar n = 0; n < VXE_VPU_NTHREADS; n++) begin : g_acc
    assign o_acc[n*VXE_VPU_ACCW +: VXE_VPU_ACCW] = regs_q[n][VXE_VPU_RIDX_ACC][VXE_VPU_ACCW-1:0];
  end

  // Tracker sees the pre-update enable mask, so arm with i_en_we uses old o_en
  vxe_vpu_rf_wbtrk u_wbtrk (
    .clk       (clk),
    .nrst      (nrst),
    .i_en      (en_q),
    .i_wb_arm  (i_wb_arm),
    .i_acc_wr  (acc_wr),
    .i_acc_th  (i_th),
    .o_wb_done (o_wb_done)
  );

  assign o_en      = en_q;
  assign o_wr_err  = wr_err_q;
  assign o_rd_data = rd_data_q;
  assign o_rd_vld  = rd_vld_q;

endmodule

// File: tb/tb_vxe_vpu_rf.sv
// Directed self-checking bench for vxe_vpu_rf.
module tb_vxe_vpu_rf;

  logic         clk;
  logic         nrst;
  logic [2:0]   i_th;
  logic [2:0]   i_ridx;
  logic         i_wr_en;
  logic [37:0]  i_data;
  logic         i_en_we;
  logic [7:0]   i_en_mask;
  logic         i_wb_arm;
  logic         o_wb_done;
  logic         o_wr_err;
  logic         i_err_clr;
  logic [2:0]   i_rd_th;
  logic [2:0]   i_rd_ridx;
  logic         i_rd_en;
  logic [37:0]  o_rd_data;
  logic         o_rd_vld;
  logic [255:0] o_acc;
  logic [7:0]   o_en;

  int total;
  int bad;

  vxe_vpu_rf dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_th      (i_th),
    .i_ridx    (i_ridx),
    .i_wr_en   (i_wr_en),
    .i_data    (i_data),
    .i_en_we   (i_en_we),
    .i_en_mask (i_en_mask),
    .i_wb_arm  (i_wb_arm),
    .o_wb_done (o_wb_done),
    .o_wr_err  (o_wr_err),
    .i_err_clr (i_err_clr),
    .i_rd_th   (i_rd_th),
    .i_rd_ridx (i_rd_ridx),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_rd_data),
    .o_rd_vld  (o_rd_vld),
    .o_acc     (o_acc),
    .o_en      (o_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i_wr_en   = 1'b0;
    i_en_we   = 1'b0;
    i_wb_arm  = 1'b0;
    i_err_clr = 1'b0;
    i_rd_en   = 1'b0;
  endtask

  task automatic set_en(input logic [7:0] m);
    i_en_we = 1'b1; i_en_mask = m;
    tick();
    quiet();
  endtask

  task automatic drive_wr(input logic [2:0] th, input logic [2:0] ridx, input logic [37:0] d);
    i_wr_en = 1'b1; i_th = th; i_ridx = ridx; i_data = d;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    quiet();
    i_th = '0; i_ridx = '0; i_data = '0; i_en_mask = '0; i_rd_th = '0; i_rd_ridx = '0;
    #12;
    nrst = 1'b1;
    tick();
    total++;
    if (o_wb_done !== 1'b1 || o_wr_err !== 1'b0 || o_rd_vld !== 1'b0 || o_en !== 8'h00 ||
        o_rd_data !== 38'h0 || o_acc !== 256'h0) begin
      bad++;
      $display("FAIL reset: done=%b err=%b vld=%b en=%h rd=%h acc=%h, required 1 0 0 00 0 0",
               o_wb_done, o_wr_err, o_rd_vld, o_en, o_rd_data, o_acc);
    end
  endtask

  task automatic test_single();
    set_en(8'h01);
    i_wb_arm = 1'b1;
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b0) begin
      bad++; $display("FAIL single_arm_done: got %b required 0", o_wb_done);
    end
    drive_wr(3'd0, 3'd0, 38'h0);
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b1 || o_acc[31:0] !== 32'h0) begin
      bad++;
      $display("FAIL single_done: done=%b acc0=%h required 1 00000000", o_wb_done, o_acc[31:0]);
    end
  endtask

  task automatic test_all_threads();
    set_en(8'hFF);
    i_wb_arm = 1'b1;
    tick();
    quiet();
    for (int t = 0; t < 8; t++) begin
      drive_wr(t[2:0], 3'd0, 38'h0_7f800000);
      tick();
      quiet();
      total++;
      if (o_wb_done !== (t == 7 ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL all_done_th%0d: got %b required %b", t, o_wb_done, (t == 7));
      end
    end
    for (int t = 0; t < 8; t++) begin
      total++;
      if (o_acc[t*32 +: 32] !== 32'h7f800000) begin
        bad++;
        $display("FAIL all_acc_lane%0d: got %h required 7f800000", t, o_acc[t*32 +: 32]);
      end
    end
  endtask

  task automatic test_disabled();
    logic [2:0] ths [6];
    ths = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
    set_en(8'hE7);
    i_wb_arm = 1'b1;
    tick();
    quiet();
    for (int k = 0; k < 6; k++) begin
      drive_wr(ths[k], 3'd0, 38'h0_41800000);
      tick();
      quiet();
    end
    total++;
    if (o_wb_done !== 1'b1 || o_wr_err !== 1'b0) begin
      bad++;
      $display("FAIL dis_done: done=%b err=%b required 1 0", o_wb_done, o_wr_err);
    end
    drive_wr(3'd3, 3'd0, 38'h0_41800000);
    tick();
    quiet();
    tick();
    total++;
    if (o_wr_err !== 1'b1 || o_acc[3*32 +: 32] !== 32'h41800000) begin
      bad++;
      $display("FAIL dis_err_set: err=%b acc3=%h required 1 41800000", o_wr_err, o_acc[127:96]);
    end
    i_err_clr = 1'b1;
    tick();
    quiet();
    total++;
    if (o_wr_err !== 1'b0) begin
      bad++; $display("FAIL dis_err_clr: got %b required 0", o_wr_err);
    end
    // Set and clear together: set wins
    drive_wr(3'd4, 3'd1, 38'h1);
    i_err_clr = 1'b1;
    tick();
    quiet();
    total++;
    if (o_wr_err !== 1'b1) begin
      bad++; $display("FAIL dis_err_prio: got %b required 1", o_wr_err);
    end
    i_err_clr = 1'b1;
    tick();
    quiet();
  endtask

  task automatic test_read_bypass();
    drive_wr(3'd2, 3'd5, 38'h3F_DEADBEEF);
    i_rd_en = 1'b1; i_rd_th = 3'd2; i_rd_ridx = 3'd5;
    tick();
    quiet();
    total++;
    if (o_rd_vld !== 1'b1 || o_rd_data !== 38'h3F_DEADBEEF) begin
      bad++;
      $display("FAIL rd_bypass: vld=%b data=%h required 1 3fdeadbeef", o_rd_vld, o_rd_data);
    end
    tick();
    total++;
    if (o_rd_vld !== 1'b0 || o_rd_data !== 38'h3F_DEADBEEF) begin
      bad++;
      $display("FAIL rd_hold: vld=%b data=%h required 0 3fdeadbeef", o_rd_vld, o_rd_data);
    end
    // Back-to-back reads: stored value, then the th3 ACC written earlier
    i_rd_en = 1'b1; i_rd_th = 3'd2; i_rd_ridx = 3'd5;
    tick();
    total++;
    if (o_rd_vld !== 1'b1 || o_rd_data !== 38'h3F_DEADBEEF) begin
      bad++;
      $display("FAIL rd_stored: vld=%b data=%h required 1 3fdeadbeef", o_rd_vld, o_rd_data);
    end
    i_rd_th = 3'd3; i_rd_ridx = 3'd0;
    tick();
    quiet();
    total++;
    if (o_rd_vld !== 1'b1 || o_rd_data !== 38'h0_41800000) begin
      bad++;
      $display("FAIL rd_b2b: vld=%b data=%h required 1 0041800000", o_rd_vld, o_rd_data);
    end
    // Non-ACC write while waiting must not complete the tracker
    set_en(8'h01);
    i_wb_arm = 1'b1;
    tick();
    quiet();
    drive_wr(3'd0, 3'd3, 38'h5);
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b0) begin
      bad++; $display("FAIL nonacc_wait: got %b required 0", o_wb_done);
    end
    drive_wr(3'd0, 3'd0, 38'h9);
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b1) begin
      bad++; $display("FAIL nonacc_finish: got %b required 1", o_wb_done);
    end
  endtask

  task automatic test_reset_mid_wait();
    set_en(8'h03);
    i_wb_arm = 1'b1;
    tick();
    quiet();
    drive_wr(3'd0, 3'd0, 38'h0_12345678);
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b0 || o_acc[31:0] !== 32'h12345678) begin
      bad++;
      $display("FAIL midwait_pre: done=%b acc0=%h required 0 12345678", o_wb_done, o_acc[31:0]);
    end
    #2;
    nrst = 1'b0;
    #1;
    total++;
    if (o_wb_done !== 1'b1 || o_acc !== 256'h0 || o_en !== 8'h00) begin
      bad++;
      $display("FAIL midwait_rst: done=%b acc=%h en=%h required 1 0 00", o_wb_done, o_acc, o_en);
    end
    #1;
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    set_en(8'h02);
    drive_wr(3'd1, 3'd0, 38'h0_00000042);
    i_wb_arm = 1'b1;
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b1 || o_acc[63:32] !== 32'h42) begin
      bad++;
      $display("FAIL arm_wr_same: done=%b acc1=%h required 1 00000042", o_wb_done, o_acc[63:32]);
    end
    // Arm with a same-cycle enable load tracks the old mask (thread 1)
    i_wb_arm = 1'b1; i_en_we = 1'b1; i_en_mask = 8'h04;
    tick();
    quiet();
    drive_wr(3'd2, 3'd0, 38'h1);
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b0 || o_en !== 8'h04) begin
      bad++;
      $display("FAIL arm_old_en: done=%b en=%h required 0 04", o_wb_done, o_en);
    end
    drive_wr(3'd1, 3'd0, 38'h2);
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b1) begin
      bad++; $display("FAIL arm_old_en_done: got %b required 1", o_wb_done);
    end
    // Arm with an empty mask stays idle
    set_en(8'h00);
    i_wb_arm = 1'b1;
    tick();
    quiet();
    total++;
    if (o_wb_done !== 1'b1) begin
      bad++; $display("FAIL arm_empty: got %b required 1", o_wb_done);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_all_threads();
    test_disabled();
    test_read_bypass();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vxe_vpu_rf.md
Name: vxe_vpu_rf

Overview:
- Per-thread VPU register file at the receiving end of the execution-unit writeback interface: th / ridx / wr_en / 38-bit data.
- Holds 8 threads x 8 registers of 38 bits.
- Exposes each thread's accumulator and enable to the execution units.
- Provides one registered read port for the control unit.
- Tracks writeback completion per thread, so the control unit knows when an issued operation has retired on every enabled thread.

Parameters:
- NTHREADS, 8, number of threads (fixed; th is 3 bits).
- NREGS, 8, registers per thread (fixed; ridx is 3 bits).
- DW, 38, register width.
- ACC_IDX, 0, ridx of the accumulator register.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_th  in  3  write thread index
- i_ridx  in  3  write register index
- i_wr_en  in  1  write strobe, single cycle per write
- i_data  in  38  write data
- i_en_we  in  1  load thread-enable mask
- i_en_mask  in  8  new thread-enable mask (bit n = thread n)
- i_wb_arm  in  1  pulse; start tracking writebacks
- o_wb_done  out  1  all armed threads have written ACC
- o_wr_err  out  1  sticky; write hit a disabled thread
- i_err_clr  in  1  clear o_wr_err
- i_rd_th  in  3  read thread
- i_rd_ridx  in  3  read register
- i_rd_en  in  1  read request
- o_rd_data  out  38  read data
- o_rd_vld  out  1  read data valid
- o_acc  out  256  thread n ACC[31:0] at bits [32n+31:32n]
- o_en  out  8  thread enable mask

Behaviour:
- Reset is asynchronous on nrst low. All registers become 0, o_en=0, pending mask=0, o_wb_done=1, o_wr_err=0, o_rd_data=0, o_rd_vld=0.
- Write:
  - When i_wr_en=1, regs[i_th][i_ridx] <= i_data at the next posedge; visible the following cycle.
  - o_acc is driven combinationally from the ACC registers, so a write to ACC shows on o_acc one cycle after the strobe.
  - Writes to a disabled thread (o_en[i_th]=0) still update storage and set o_wr_err.
- Enable: i_en_we=1 loads o_en <= i_en_mask next cycle.
- Read:
  - i_rd_en=1 gives o_rd_data/o_rd_vld one cycle later.
  - o_rd_vld is a single-cycle pulse per request; back-to-back reads are allowed every cycle.
  - o_rd_data holds its last value when o_rd_vld=0.
  - A same-cycle write to the same th/ridx is bypassed: the read returns i_data.
- Writeback tracker, with a pending mask of 8 bits:
  - IDLE (pending=0, o_wb_done=1) -> on i_wb_arm: pending <= o_en, go to WAIT. If o_en=0, stay IDLE and o_wb_done stays 1.
  - WAIT: each ACC write (i_ridx=ACC_IDX) clears pending[i_th]. Non-ACC writes do not clear.
  - WAIT: o_wb_done=0 starting the cycle after arm. When pending becomes 0, o_wb_done=1 next cycle and the tracker returns to IDLE.
  - i_wb_arm and an ACC write in the same cycle: the write is applied after arming (its bit is cleared).
  - i_wb_arm in WAIT re-arms: pending <= o_en, with the same-cycle clear rule.
  - A second ACC write to an already-cleared thread is harmless.
  - i_en_we in the same cycle as i_wb_arm: arming uses the old o_en.
- o_wr_err priority: a set in the same cycle as i_err_clr wins.
- Reset mid-WAIT: immediate return to IDLE, o_wb_done=1.

Decomposition:
- Shared package vxe_vpu_pkg holds:
  - VXE_VPU_NTHREADS=8, VXE_VPU_NREGS=8, VXE_VPU_RDW=38;
  - register index constants (VXE_VPU_RIDX_ACC=0);
  - writeback tracker state encoding (WB_IDLE, WB_WAIT).
- One sub-module is natural: vxe_vpu_rf_wbtrk (pending mask, state, o_wb_done).
- Storage and the read port stay in the top.

Test Plan:
- Reset then o_en=8'h01, arm, write th0 ridx0 data 38'h0000000000 -> o_wb_done falls the cycle after arm; rises the cycle after the write; o_acc[31:0]=0.
- o_en=8'hFF, arm, ACC writes 32'h7f800000 for th0..th7 one per cycle:
  - o_wb_done stays 0 through th6;
  - o_wb_done rises 1 cycle after the th7 write;
  - all o_acc lanes = 7f800000.
- o_en=8'hE7 (th3, th4 disabled), arm, ACC writes 32'h41800000 to th0,1,2,5,6,7 -> o_wb_done=1, o_wr_err=0. A further write to th3 -> o_wr_err=1 until i_err_clr.
- Write th2 ridx5 38'h3F_DEADBEEF while reading th2 ridx5 in the same cycle -> o_rd_data=38'h3F_DEADBEEF, o_rd_vld=1 one cycle later. A non-ACC write during WAIT does not clear pending.
- Arm with o_en=8'h03, write th0 ACC, pull nrst low mid-WAIT -> o_wb_done=1, o_acc=0, o_en=0 immediately.
- Arm in the same cycle as th1 ACC write, o_en=8'h02 -> tracker completes; o_wb_done=1 the next cycle.
